// File: rtl/cascaded_alu_seq_if.sv
// Operation interface for the cascaded ALU: request/operands from the
// master, ready/completion/result back from the slave (the datapath).
interface cascaded_alu_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_STAGES = 2
);
  logic                      start_op;
  logic [DATA_WIDTH-1:0]     A;
  logic [DATA_WIDTH-1:0]     B;
  logic [3*NUM_STAGES-1:0]   op_vec;
  logic [NUM_STAGES-1:0]     bypass;
  logic                      ready;
  logic                      end_op;
  logic [2*DATA_WIDTH-1:0]   result;

  modport master (
    output start_op, A, B, op_vec, bypass,
    input  ready, end_op, result
  );

  modport slave (
    input  start_op, A, B, op_vec, bypass,
    output ready, end_op, result
  );
endinterface

// File: rtl/cascaded_alu_seq.sv
// Sequential cascaded ALU: NUM_STAGES stages evaluated one after another
// on a single shared execution unit. Each stage consumes the halves of the
// previous stage's double-width result; multiplies take MUL_LATENCY cycles.
module cascaded_alu_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_STAGES  = 2,
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  cascaded_alu_seq_if.slave  bus
);
  localparam int RW   = 2 * DATA_WIDTH;
  localparam int OPW  = 3 * NUM_STAGES;
  localparam int CNTW = $clog2(MUL_LATENCY + 1);
  localparam int IDXW = $clog2(NUM_STAGES + 1);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(MUL_LATENCY - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_STAGES - 1);
  localparam bit              MUL_MULTI = (MUL_LATENCY > 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]        opVec_q, opVec_d;
  logic [NUM_STAGES-1:0] byp_q, byp_d;
  logic [RW-1:0]         result_q, result_d;
  logic                  end_q, end_d;

  logic [2:0]            curOp;
  logic                  curByp;
  logic [RW-1:0]         stageRes;
  logic                  advance;

  // Pick the op code and bypass bit belonging to the stage being executed
  always_comb begin
    curOp  = 3'b000;
    curByp = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (idx_q == IDXW'(s)) begin
        curOp  = opVec_q[3*s +: 3];
        curByp = byp_q[s];
      end
    end
  end

  // Shared execution unit: evaluates the current stage on the latched operands
  always_comb begin
    logic [RW-1:0] ea;
    logic [RW-1:0] eb;
    ea       = {{DATA_WIDTH{1'b0}}, a_q};
    eb       = {{DATA_WIDTH{1'b0}}, b_q};
    stageRes = '0;
    if (curByp) begin
      stageRes = {a_q, b_q};
    end else begin
      case (curOp)
        3'b000:  stageRes = ea * eb;
        3'b001:  stageRes = ea + eb;
        3'b010:  stageRes = ea - eb;
        3'b011:  stageRes = ea + eb + RW'(1);
        3'b100:  stageRes = ea | eb;
        3'b101:  stageRes = ea & eb;
        3'b110:  stageRes = ea ^ eb;
        default: stageRes = {~a_q, ~b_q};
      endcase
    end
  end

  // Next-state logic: accept, per-stage sequencing, multiply wait and completion
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    opVec_d  = opVec_q;
    byp_d    = byp_q;
    result_d = result_q;
    end_d    = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_op) begin
          a_d     = bus.A;
          b_d     = bus.B;
          opVec_d = bus.op_vec;
          byp_d   = bus.bypass;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!curByp && curOp == 3'b000 && MUL_MULTI) begin
          cnt_d   = CNTW'(1);
          state_d = MUL_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        result_d = stageRes;
        end_d    = 1'b1;
        idx_d    = '0;
        state_d  = IDLE;
      end else begin
        a_d     = stageRes[RW-1:DATA_WIDTH];
        b_d     = stageRes[DATA_WIDTH-1:0];
        idx_d   = idx_q + IDXW'(1);
        state_d = EXEC;
      end
    end
  end

  // State and datapath registers; synchronous active-low reset drops any op
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opVec_q  <= '0;
      byp_q    <= '0;
      result_q <= '0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opVec_q  <= opVec_d;
      byp_q    <= byp_d;
      result_q <= result_d;
      end_q    <= end_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.end_op = end_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_cascaded_alu_seq.sv
// Testbench for cascaded_alu_seq: directed table vectors, mid-operation
// corner sequences and randomized ops against a behavioural model.
module tb_cascaded_alu_seq;
  localparam int W  = 16;
  localparam int NS = 2;
  localparam int ML = 3;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  // Free-running clock
  always #5 clk = ~clk;

  cascaded_alu_seq_if #(.DATA_WIDTH(W), .NUM_STAGES(NS)) bus ();

  cascaded_alu_seq #(
    .DATA_WIDTH (W),
    .NUM_STAGES (NS),
    .MUL_LATENCY(ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [3*NS-1:0] ops;
    logic [NS-1:0]   byp;
    logic [2*W-1:0]  expRes;
    int              expLat;
  } vector_t;

  vector_t vectors[4];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: apply each stage's arithmetic rule in order, summing latencies
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3*NS-1:0] ops, input logic [NS-1:0] byp,
                                   output logic [2*W-1:0] res, output int lat);
    logic [W-1:0]   ca;
    logic [W-1:0]   cb;
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    logic [2:0]     op;
    ca  = a;
    cb  = b;
    lat = 0;
    res = '0;
    for (int s = 0; s < NS; s++) begin
      op = ops[3*s +: 3];
      xa = 32'(ca);
      xb = 32'(cb);
      if (byp[s]) res = {ca, cb};
      else begin
        case (op)
          3'd0: res = xa * xb;
          3'd1: res = xa + xb;
          3'd2: res = xa - xb;
          3'd3: res = xa + xb + 32'd1;
          3'd4: res = xa | xb;
          3'd5: res = xa & xb;
          3'd6: res = xa ^ xb;
          default: res = {~ca, ~cb};
        endcase
      end
      lat += (byp[s] || op != 3'd0) ? 1 : ML;
      ca = res[2*W-1:W];
      cb = res[W-1:0];
    end
  endfunction

  // Present a request and let the next edge accept it; scramble inputs afterwards
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3*NS-1:0] ops, input logic [NS-1:0] byp);
    bus.start_op = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.op_vec   = ops;
    bus.bypass   = byp;
    @(posedge clk);
    #1;
    bus.start_op = 1'b0;
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
    bus.op_vec   = (3*NS)'($urandom);
    bus.bypass   = NS'($urandom);
  endtask

  // Wait for completion, checking latency, result, ready behaviour and hold
  task automatic checkOutput(input string name, input logic [2*W-1:0] expRes, input int expLat,
                             input bit noise, input bit holdCheck, input logic [2*W-1:0] holdVal);
    int lat       = 0;
    bit readyBad  = 1'b0;
    bit holdBad   = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.end_op) begin
        lat = k;
        break;
      end
      if (bus.ready) readyBad = 1'b1;
      if (bus.result !== holdVal) holdBad = 1'b1;
      if (noise) begin
        bus.start_op = 1'($urandom_range(0, 1));
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
      end
    end
    bus.start_op = 1'b0;
    checkValue({name, ".latency"}, 32'(lat), 32'(expLat));
    checkValue({name, ".result"}, bus.result, expRes);
    checkValue({name, ".readyAtEnd"}, 32'(bus.ready), 32'd1);
    checkValue({name, ".readyLowWhileBusy"}, 32'(readyBad), 32'd0);
    if (holdCheck) checkValue({name, ".resultHeld"}, 32'(holdBad), 32'd0);
  endtask

  // end_op must drop one cycle after it rose
  task automatic checkPulse(input string name);
    @(posedge clk);
    @(negedge clk);
    checkValue({name, ".endOpPulse"}, 32'(bus.end_op), 32'd0);
  endtask

  initial begin
    logic [2*W-1:0] rRes;
    int             rLat;
    bit             sawEnd;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [3*NS-1:0] rops;
    logic [NS-1:0]  rbyp;

    vectors[0] = '{16'h0003, 16'h0005, 6'b100_001, 2'b00, 32'h0000_0008, 2};
    vectors[1] = '{16'h0002, 16'h0003, 6'b111_000, 2'b00, 32'hFFFF_FFF9, 4};
    vectors[2] = '{16'h0001, 16'h0002, 6'b101_010, 2'b00, 32'h0000_FFFF, 2};
    vectors[3] = '{16'h1234, 16'h5678, 6'b110_000, 2'b01, 32'h0000_444C, 2};

    bus.start_op = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.op_vec   = '0;
    bus.bypass   = '0;
    rst          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("reset.ready", 32'(bus.ready), 32'd1);
    checkValue("reset.endOp", 32'(bus.end_op), 32'd0);
    checkValue("reset.result", bus.result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].ops, vectors[i].byp);
      checkOutput($sformatf("vec%0d", i), vectors[i].expRes, vectors[i].expLat, 1'b0, 1'b0, '0);
      checkPulse($sformatf("vec%0d", i));
    end

    applyStimulus(16'h0002, 16'h0003, 6'b111_000, 2'b00);
    checkOutput("ignoreStart", 32'hFFFF_FFF9, 4, 1'b1, 1'b1, 32'h0000_444C);
    checkPulse("ignoreStart");

    applyStimulus(16'h0002, 16'h0003, 6'b111_000, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkValue("midReset.ready", 32'(bus.ready), 32'd1);
    checkValue("midReset.endOp", 32'(bus.end_op), 32'd0);
    checkValue("midReset.result", bus.result, 32'd0);
    sawEnd = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.end_op) sawEnd = 1'b1;
    end
    checkValue("midReset.noEndOp", 32'(sawEnd), 32'd0);
    applyStimulus(16'h0003, 16'h0005, 6'b100_001, 2'b00);
    checkOutput("afterReset", 32'h0000_0008, 2, 1'b0, 1'b0, '0);
    checkPulse("afterReset");

    rst          = 1'b0;
    bus.start_op = 1'b1;
    bus.A        = 16'h0002;
    bus.B        = 16'h0003;
    bus.op_vec   = 6'b111_000;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.start_op = 1'b0;
    @(negedge clk);
    checkValue("resetWins.ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkValue("resetWins.stillIdle", 32'(bus.ready), 32'd1);

    applyStimulus(16'h0003, 16'h0005, 6'b100_001, 2'b00);
    checkOutput("b2bFirst", 32'h0000_0008, 2, 1'b0, 1'b0, '0);
    applyStimulus(16'h0001, 16'h0002, 6'b101_010, 2'b00);
    checkOutput("b2bSecond", 32'h0000_FFFF, 2, 1'b0, 1'b1, 32'h0000_0008);
    checkPulse("b2bSecond");

    for (int i = 0; i < 24; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rops = (3*NS)'($urandom);
      rbyp = ((i % 3) == 0) ? NS'($urandom) : '0;
      if ((i % 4) == 1) rops[2:0] = 3'b000;
      refModel(ra, rb, rops, rbyp, rRes, rLat);
      applyStimulus(ra, rb, rops, rbyp);
      checkOutput($sformatf("rand%0d", i), rRes, rLat, 1'(i % 2), 1'b0, '0);
      if ((i % 5) != 4) checkPulse($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
